// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-cycle logical shift sequencer around a single-bit shifter
//
// shift_unit: combinational one-position logical shifter.
//   data_i  [N-1:0]  operand
//   shamt_i [1:0]    00 pass-through, 01 right by one, 10 left by one, 11 pass-through
//   data_o  [N-1:0]  shifted operand, vacated bit filled with 0
//
// shift_seq_ctrl: applies 0..2^AW-1 single-bit shifts, one per clock.
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   request, sampled only while idle
//   dir      in   0 = logical right, 1 = logical left
//   amount   in   number of single-bit shifts
//   data_in  in   operand, latched with start
//   busy     out  high while shifting and during the done cycle
//   done     out  one-cycle pulse, result valid
//   result   out  shifted value, held until the next completion or reset

module shift_unit #(
    parameter int N = 8
) (
    input  logic [N-1:0] data_i,
    input  logic [1:0]   shamt_i,
    output logic [N-1:0] data_o
);
    always_comb begin
        data_o = data_i;
        case (shamt_i)
            2'b01:   data_o = {1'b0, data_i[N-1:1]};
            2'b10:   data_o = {data_i[N-2:0], 1'b0};
            default: data_o = data_i;
        endcase
    end
endmodule

module shift_seq_ctrl #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          dir,
    input  logic [AW-1:0] amount,
    input  logic [N-1:0]  data_in,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  acc_q;
    logic [AW-1:0] cnt_q;
    logic          dir_q;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  result_q;

    logic [1:0]    shamt_d;
    logic [N-1:0]  acc_d;

    // The shifter only moves data while in SHIFT; elsewhere it passes through.
    always_comb begin
        shamt_d = 2'b00;
        if (state_q == ST_SHIFT) begin
            shamt_d = dir_q ? 2'b10 : 2'b01;
        end
    end

    shift_unit #(.N(N)) u_shift (
        .data_i  (acc_q),
        .shamt_i (shamt_d),
        .data_o  (acc_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q  <= data_in;
                        cnt_q  <= amount;
                        dir_q  <= dir;
                        busy_q <= 1'b1;
                        if (amount == '0) begin
                            // Zero-length shift skips straight to completion.
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= data_in;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - AW'(1);
                    // Exit on the last step so cnt never wraps; the final
                    // shifted value goes straight into result.
                    if (cnt_q == AW'(1)) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= acc_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed scoreboard bench for shift_seq_ctrl
module tb_shift_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       start, start4;
    logic       dir;
    logic [2:0] amount3;
    logic [3:0] amount4;
    logic [7:0] data_in;
    logic       busy, done, busy4, done4;
    logic [7:0] result, result4;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    shift_seq_ctrl #(.N(8), .AW(3)) dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .amount(amount3),
        .data_in(data_in), .busy(busy), .done(done), .result(result)
    );

    shift_seq_ctrl #(.N(8), .AW(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .dir(dir), .amount(amount4),
        .data_in(data_in), .busy(busy4), .done(done4), .result(result4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic dr, input int amt);
        logic [7:0] r;
        r = dr ? (d << amt) : (d >> amt);
        return r;
    endfunction

    // One complete operation on either instance; expected result goes through the scoreboard.
    task automatic do_op(input bit w4, input logic [7:0] d, input logic dr, input int amt);
        logic [7:0] e;
        logic [7:0] pop;
        bit got;
        e = ref_shift(d, dr, amt);
        sb.push_back(e);
        data_in = d;
        dir     = dr;
        amount3 = amt[2:0];
        amount4 = amt[3:0];
        if (w4) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start4  = 1'b0;
        data_in = ~d;
        dir     = ~dr;
        amount3 = 3'd0;
        amount4 = 4'd0;
        got = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            check("busy_during_op", w4 ? busy4 : busy, 1);
            if (w4 ? done4 : done) begin
                check("done_latency", c, amt + 1);
                pop = sb.pop_front();
                check("result", w4 ? result4 : result, pop);
                got = 1'b1;
                break;
            end
        end
        if (!got) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_one_cycle", w4 ? done4 : done, 0);
        check("busy_after_done", w4 ? busy4 : busy, 0);
        check("result_held", w4 ? result4 : result, e);
    endtask

    initial begin
        bit saw_done;
        logic [7:0] pop;
        reset = 1'b1; start = 0; start4 = 0; dir = 0;
        amount3 = 0; amount4 = 0; data_in = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_result4", result4, 0);
        reset = 1'b0;
        @(negedge clk);

        // Load a nonzero result, then abort an operation mid-shift.
        do_op(0, 8'hB5, 1'b0, 3);
        data_in = 8'hB5; dir = 0; amount3 = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_result_stays", result, 0);

        do_op(0, 8'hB5, 1'b0, 3);   // 0x16
        do_op(0, 8'hB5, 1'b1, 2);   // 0xD4
        do_op(0, 8'h5A, 1'b0, 0);   // pass-through
        do_op(0, 8'hFF, 1'b1, 7);   // 0x80
        do_op(0, 8'h81, 1'b0, 7);   // 0x01
        do_op(1, 8'hFF, 1'b0, 12);  // shifted fully out
        do_op(1, 8'hC3, 1'b1, 15);

        // start held high with amount=1: accepted every third cycle, busy starts ignored.
        dir = 0; amount3 = 3'd1; start = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) begin
                @(negedge clk);
                check("hold_busy", busy, (c % 3) != 0);
                check("hold_done", done, (c % 3) == 2);
                if (done) begin
                    pop = sb.pop_front();
                    check("hold_result", result, pop);
                end
            end
            data_in = 8'(8'h40 + 8'(c * 7));
            if (c % 3 == 0 && c < 9) sb.push_back(data_in >> 1);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
